// File: rtl/program_counter.sv
// Word-addressed program counter for the instruction-fetch stage.
// Runs a program inside one fixed-size slot of instruction memory. It can sequence, branch
// or jump within that slot, and it traps any attempt to leave it.
module program_counter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SLOT_SIZE  = 512,
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned SLOT_BITS  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load_slot,
    input  logic [SLOT_BITS-1:0]  slot_sel,
    input  logic                  halt,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic                  branch,
    input  logic [ADDR_WIDTH-1:0] branch_offset,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [SLOT_BITS-1:0]  slot,
    output logic                  halted,
    output logic                  fault,
    output logic [31:0]           instr_count
);

    localparam int unsigned OffBits = $clog2(SLOT_SIZE);

    typedef enum logic [1:0] {StRun, StHalted, StFault} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [SLOT_BITS-1:0]  slot_q, slot_d;
    logic [31:0]           instr_count_q, instr_count_d;

    logic [ADDR_WIDTH-1:0] base, limit, next_addr;
    logic                  in_range;

    // Slots are power-of-two aligned, so the base is the slot index shifted into the top bits.
    function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [SLOT_BITS-1:0] s);
        return ADDR_WIDTH'(s) << OffBits;
    endfunction

    // Candidate fetch address and its bounds check against the running slot.
    always_comb begin
        base  = slot_base(slot_q);
        limit = base + ADDR_WIDTH'(SLOT_SIZE - 1);
        if (jump) begin
            next_addr = jump_target;
        end else if (branch) begin
            next_addr = pc_q + ADDR_WIDTH'(1) + branch_offset;
        end else begin
            next_addr = pc_q + ADDR_WIDTH'(1);
        end
        // Unsigned compare: a wrap through zero lands below base and faults.
        in_range = (next_addr >= base) && (next_addr <= limit);
    end

    // State register and datapath flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StRun;
            pc_q          <= '0;
            slot_q        <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            slot_q        <= slot_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Next-state logic: load_slot overrides everything, otherwise only RUN with enable advances.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        slot_d        = slot_q;
        instr_count_d = instr_count_q;
        if (load_slot) begin
            state_d       = StRun;
            pc_d          = slot_base(slot_sel);
            slot_d        = slot_sel;
            instr_count_d = '0;
        end else if (state_q == StRun && enable) begin
            if (halt) begin
                state_d       = StHalted;
                instr_count_d = instr_count_q + 32'd1;
            end else if (in_range) begin
                pc_d          = next_addr;
                instr_count_d = instr_count_q + 32'd1;
            end else begin
                // pc keeps pointing at the instruction that tried to escape.
                state_d = StFault;
            end
        end
    end

    // Outputs, all taken straight from flops.
    always_comb begin
        pc          = pc_q;
        slot        = slot_q;
        halted      = (state_q == StHalted);
        fault       = (state_q == StFault);
        instr_count = instr_count_q;
    end

    // A requested slot must exist in instruction memory.
    slot_sel_valid_a: assert property (
        @(posedge clock) disable iff (reset) load_slot |-> (32'(slot_sel) < NUM_SLOTS)
    );

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: the driver pushes model predictions, and the monitor
// checks them one edge later.
module tb_program_counter;

    localparam int unsigned SlotSize = 512;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        load_slot = 1'b0;
    logic [1:0]  slot_sel = '0;
    logic        halt = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        branch = 1'b0;
    logic [31:0] branch_offset = '0;
    logic [31:0] pc;
    logic [1:0]  slot;
    logic        halted;
    logic        fault;
    logic [31:0] instr_count;

    program_counter dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .load_slot     (load_slot),
        .slot_sel      (slot_sel),
        .halt          (halt),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch        (branch),
        .branch_offset (branch_offset),
        .pc            (pc),
        .slot          (slot),
        .halted        (halted),
        .fault         (fault),
        .instr_count   (instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  slot;
        logic        halted;
        logic        fault;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: 0 = running, 1 = halted, 2 = faulted.
    longint unsigned m_pc;
    int              m_slot;
    int              m_state;
    longint unsigned m_cnt;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_slot = 0; m_state = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit ld, input int sel, input bit en, input bit h, input bit j,
                              input longint unsigned jt, input bit br, input longint unsigned bo);
        longint unsigned nxt;
        longint unsigned lo;
        if (ld) begin
            m_slot = sel; m_pc = sel * SlotSize; m_state = 0; m_cnt = 0;
        end else if (m_state == 0 && en) begin
            if (h) begin
                m_state = 1;
                m_cnt = (m_cnt + 1) % 64'h1_0000_0000;
            end else begin
                if (j) nxt = jt;
                else if (br) nxt = (m_pc + 1 + bo) % 64'h1_0000_0000;
                else nxt = (m_pc + 1) % 64'h1_0000_0000;
                lo = m_slot * SlotSize;
                if (nxt >= lo && nxt <= lo + SlotSize - 1) begin
                    m_pc = nxt;
                    m_cnt = (m_cnt + 1) % 64'h1_0000_0000;
                end else begin
                    m_state = 2;
                end
            end
        end
    endtask

    // Drive one cycle of stimulus and record the model's prediction for the next edge.
    task automatic cyc(input bit ld, input int sel, input bit en, input bit h, input bit j,
                       input logic [31:0] jt, input bit br, input logic [31:0] bo);
        exp_t e;
        @(negedge clock);
        load_slot = ld; slot_sel = 2'(sel); enable = en; halt = h;
        jump = j; jump_target = jt; branch = br; branch_offset = bo;
        model_step(ld, sel, en, h, j, jt, br, bo);
        e.pc = 32'(m_pc); e.slot = 2'(m_slot); e.halted = (m_state == 1);
        e.fault = (m_state == 2); e.cnt = 32'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        load_slot = 0; enable = 0; halt = 0; jump = 0; branch = 0;
        jump_target = '0; branch_offset = '0;
    endtask

    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    // Monitor: every edge is an output event for this block.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", pc, e.pc);
                check("slot", slot, e.slot);
                check("halted", halted, e.halted);
                check("fault", fault, e.fault);
                check("instr_count", instr_count, e.cnt);
            end
        end
    end

    initial begin
        longint unsigned lo;
        logic [31:0]     jt;
        logic [31:0]     bo;
        int              r;

        model_reset();
        #1;
        check("reset_pc", pc, 0);
        check("reset_halted", halted, 0);
        check("reset_fault", fault, 0);
        check("reset_count", instr_count, 0);
        repeat (2) @(negedge clock);
        reset = 0;

        // Run to pc=300, then hit reset asynchronously mid-cycle.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (300) cyc(0, 0, 1, 0, 0, 0, 0, 0);
        settle();
        check("pre_reset_pc", pc, 300);
        idle_inputs();
        reset = 1;
        #1;
        check("async_reset_pc", pc, 0);
        check("async_reset_count", instr_count, 0);
        model_reset();
        @(negedge clock);
        reset = 0;
        repeat (3) cyc(0, 0, 1, 0, 0, 0, 0, 0);
        settle();
        check("post_reset_pc", pc, 3);
        check("post_reset_count", instr_count, 3);

        // Slot 2: run off the end of the slot.
        cyc(1, 2, 0, 0, 0, 0, 0, 0);
        settle();
        check("load2_pc", pc, 1024);
        check("load2_count", instr_count, 0);
        repeat (511) cyc(0, 0, 1, 0, 0, 0, 0, 0);
        settle();
        check("slot2_end_pc", pc, 1535);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        settle();
        check("runoff_fault", fault, 1);
        check("runoff_pc", pc, 1535);
        check("runoff_count", instr_count, 511);

        // Slot 1: backwards branches to the base and just below it.
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 600, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 1, -32'sd89);
        settle();
        check("branch_base_pc", pc, 512);
        cyc(0, 0, 1, 0, 0, 0, 1, -32'sd2);
        settle();
        check("branch_below_fault", fault, 1);
        check("branch_below_pc", pc, 512);

        // Slot 0: jump beats branch, then jump one past the limit.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 10, 0, 0);
        cyc(0, 0, 1, 0, 1, 100, 1, 50);
        settle();
        check("jump_wins_pc", pc, 100);
        cyc(0, 0, 1, 0, 1, 512, 0, 0);
        settle();
        check("jump_out_fault", fault, 1);

        // Slot 3: halt freezes everything until the next load_slot.
        cyc(1, 3, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 1600, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0, 0);
        settle();
        check("halt_halted", halted, 1);
        check("halt_pc", pc, 1600);
        check("halt_count", instr_count, 2);
        repeat (5) cyc(0, 0, 1, 0, 1, 1700, 0, 0);
        settle();
        check("halted_hold_pc", pc, 1600);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        settle();
        check("reload_pc", pc, 512);
        check("reload_halted", halted, 0);
        check("reload_count", instr_count, 0);

        // Stall ignores jump; load_slot clears a fault.
        cyc(0, 0, 0, 0, 1, 5, 0, 0);
        settle();
        check("stall_pc", pc, 512);
        cyc(0, 0, 1, 0, 1, 5, 0, 0);
        cyc(1, 2, 0, 0, 0, 0, 0, 0);
        settle();
        check("fault_clear", fault, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            lo = longint'(m_slot) * SlotSize;
            r = int'($urandom_range(0, 99));
            if (r < 85) jt = 32'(lo + $urandom_range(0, SlotSize - 1));
            else if (r < 90) jt = 32'(lo + SlotSize);
            else if (r < 95) jt = 32'(lo - 1);
            else jt = $urandom;
            bo = 32'($urandom_range(0, 80)) - 32'd40;
            if ($urandom_range(0, 999) < 3) bo = 32'hFFFF_F000;
            cyc($urandom_range(0, 99) < 5, int'($urandom_range(0, 3)),
                $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 10, jt, $urandom_range(0, 99) < 25, bo);
        end

        // Bounded drain of outstanding predictions.
        @(negedge clock);
        idle_inputs();
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Word-addressed program counter for the instruction-fetch stage.
- Its pc output feeds instruction memory and the seven-segment program-number display.
- Instruction memory is partitioned into NUM_SLOTS program slots of SLOT_SIZE words each.
- The block starts a program at its slot base, sequences, branches and jumps inside that slot, and traps any attempt to leave it.

Parameters:
- ADDR_WIDTH, 32, width of pc and address operands
- SLOT_SIZE, 512, words per program slot (power of two)
- NUM_SLOTS, 4, number of program slots
- SLOT_BITS, 2, log2(NUM_SLOTS)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  advance pc this cycle (0 = pipeline stall)
- load_slot  in  1  start program in slot slot_sel
- slot_sel  in  SLOT_BITS  slot requested by load_slot
- halt  in  1  current instruction is a program-end/halt
- jump  in  1  absolute jump request
- jump_target  in  ADDR_WIDTH  absolute word address for jump
- branch  in  1  relative branch taken
- branch_offset  in  ADDR_WIDTH  signed word offset, relative to pc+1
- pc  out  ADDR_WIDTH  current fetch address
- slot  out  SLOT_BITS  slot currently executing
- halted  out  1  state is HALTED
- fault  out  1  state is FAULT
- instr_count  out  32  instructions retired since last load_slot

Behaviour:
- Reset (async, immediate): pc=0, slot=0, state=RUN, halted=0, fault=0, instr_count=0.
- States: RUN, HALTED, FAULT. halted=(state==HALTED), fault=(state==FAULT); both are registered.
- base = slot*SLOT_SIZE; limit = base+SLOT_SIZE-1.
- Per-edge priority: load_slot > state gating > enable > halt > jump > branch > sequential increment.
- load_slot=1 (any state, enable ignored): pc=slot_sel*SLOT_SIZE, slot=slot_sel, state=RUN, instr_count=0.
- HALTED or FAULT without load_slot: all registers hold; halt/jump/branch are ignored.
- RUN, enable=0: all registers hold.
- RUN, enable=1, halt=1: state=HALTED, pc holds, instr_count+1.
- RUN, enable=1, halt=0: candidate next address is selected by priority:
  - jump=1: next = jump_target.
  - else branch=1: next = pc+1+branch_offset, modulo 2^ADDR_WIDTH.
  - else: next = pc+1, modulo 2^ADDR_WIDTH.
- Bounds check is unsigned: base <= next <= limit.
  - In range: pc=next, instr_count+1.
  - Out of range: state=FAULT, pc holds (points at the offending instruction), instr_count unchanged.
  - Sequential increment from limit faults (program ran off the slot end).
  - Wrap-around through 2^ADDR_WIDTH lands out of range and faults.
- jump and branch both asserted: jump wins; branch is ignored.
- instr_count wraps at 2^32 without saturating.
- slot changes only on load_slot or reset, never on pc arithmetic.
- Latency: all outputs update one edge after the qualifying input, except on reset (immediate).

Test Plan:
- Reset with pc=300 mid-run, then release, then enable=1 for 3 cycles -> pc=0 immediately on reset, then 1,2,3; slot=0; instr_count=3.
- load_slot=1, slot_sel=2, one cycle -> pc=1024, slot=2, instr_count=0. Then enable with no control for 511 cycles -> pc=1535. One more cycle -> fault=1, pc stays 1535, instr_count=511.
- In slot 1 at pc=600, branch=1 with branch_offset=-89 -> pc=512. Then branch_offset=-2 -> fault=1, pc=512.
- In slot 0 at pc=10, jump=1 and branch=1 together, jump_target=100 -> pc=100. Then jump_target=512 -> fault=1.
- In slot 3 at pc=1600, halt=1 -> halted=1, pc=1600, instr_count+1. Then jump and enable for 5 cycles -> all held. Then load_slot with slot_sel=1 -> pc=512, halted=0, instr_count=0.
- In RUN, enable=0 with jump=1 and jump_target=5 -> pc unchanged. Assert load_slot while in FAULT -> state=RUN, fault=0 on the next edge.
